// File: rtl/thresholding_dwc_pkg.sv
// Shared types and elaboration helpers for the thresholding stream width converter.
package thresholding_dwc_pkg;

    typedef enum logic [1:0] {DWC_DOWN, DWC_UP, DWC_EQ} dwc_mode_e;
    typedef enum logic {EMPTY, HOLD} dwc_state_e;

    // AXI-stream tdata is padded up to a whole number of bytes.
    function automatic int unsigned padded_width(input int unsigned n);
        return ((n + 7) / 8) * 8;
    endfunction

    function automatic dwc_mode_e dwc_mode(input int unsigned in_pe, input int unsigned out_pe);
        if (in_pe > out_pe) return DWC_DOWN;
        if (out_pe > in_pe) return DWC_UP;
        return DWC_EQ;
    endfunction

    function automatic int unsigned dwc_ratio(input int unsigned in_pe, input int unsigned out_pe);
        return (in_pe >= out_pe) ? in_pe / out_pe : out_pe / in_pe;
    endfunction

endpackage

// File: rtl/thresholding_dwc.sv
// Repacks an IN_PE-element AXI stream into OUT_PE elements per beat, lane 0 at the LSB.
// Optional frame tlast generation is enabled by defining THRESH_DWC_TLAST_EN.
module thresholding_dwc
    import thresholding_dwc_pkg::*;
#(
    parameter int unsigned ELEM_WIDTH  = 8,
    parameter int unsigned IN_PE       = 4,
    parameter int unsigned OUT_PE      = 1,
    parameter int unsigned FRAME_ELEMS = 16
) (
    input  logic                                          ap_clk,
    input  logic                                          ap_rst,
    output logic                                          input_tready,
    input  logic                                          input_tvalid,
    input  logic [padded_width(IN_PE*ELEM_WIDTH)-1:0]     input_tdata,
    input  logic                                          output_tready,
    output logic                                          output_tvalid,
    output logic [padded_width(OUT_PE*ELEM_WIDTH)-1:0]    output_tdata
`ifdef THRESH_DWC_TLAST_EN
    ,
    output logic                                          output_tlast
`endif
);

    localparam int unsigned IN_DW  = IN_PE * ELEM_WIDTH;
    localparam int unsigned OUT_DW = OUT_PE * ELEM_WIDTH;
    localparam int unsigned OUT_TW = padded_width(OUT_DW);
    localparam dwc_mode_e   MODE   = dwc_mode(IN_PE, OUT_PE);
    localparam int unsigned R      = dwc_ratio(IN_PE, OUT_PE);
    localparam int unsigned MAX_PE = (IN_PE > OUT_PE) ? IN_PE : OUT_PE;

    if ((IN_PE % OUT_PE != 0) && (OUT_PE % IN_PE != 0)) begin : g_bad_ratio
        $error("thresholding_dwc: IN_PE and OUT_PE must divide one another");
    end
    if (FRAME_ELEMS % MAX_PE != 0) begin : g_bad_frame
        $error("thresholding_dwc: FRAME_ELEMS must be a multiple of max(IN_PE,OUT_PE)");
    end

    logic [IN_DW-1:0]  in_data;
    logic              in_ready_c;
    logic              out_valid;
    logic [OUT_DW-1:0] out_data;

    assign in_data = input_tdata[IN_DW-1:0];

    if (MODE == DWC_DOWN) begin : g_down
        localparam int unsigned IDX_W = $clog2(R);
        dwc_state_e       state_q, state_d;
        logic [IDX_W-1:0] idx_q, idx_d;
        logic [IN_DW-1:0] word_q, word_d;
        logic             last_c, in_fire_c, out_fire_c;

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                state_q <= EMPTY;
                idx_q   <= '0;
                word_q  <= '0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                word_q  <= word_d;
            end
        end

        // Held word shifts down one sub-word per output transfer, so lane 0 is always on the port.
        always_comb begin
            state_d    = state_q;
            idx_d      = idx_q;
            word_d     = word_q;
            last_c     = (idx_q == IDX_W'(R - 1));
            in_ready_c = (state_q == EMPTY) || (last_c && output_tready);
            in_fire_c  = input_tvalid && in_ready_c;
            out_fire_c = (state_q == HOLD) && output_tready;
            if (in_fire_c) begin
                state_d = HOLD;
                idx_d   = '0;
                word_d  = in_data;
            end else if (out_fire_c) begin
                word_d = word_q >> OUT_DW;
                if (last_c) begin
                    state_d = EMPTY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end

        assign out_valid = (state_q == HOLD);
        assign out_data  = word_q[OUT_DW-1:0];
    end else if (MODE == DWC_UP) begin : g_up
        localparam int unsigned CNT_W = $clog2(R);
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [OUT_DW-1:0] acc_q, acc_d, data_q, data_d;
        logic              valid_q, valid_d, in_fire_c;

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                cnt_q   <= '0;
                acc_q   <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                acc_q   <= acc_d;
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        // New beats enter at the top; after R beats the first one has reached lane 0.
        always_comb begin
            cnt_d      = cnt_q;
            acc_d      = acc_q;
            data_d     = data_q;
            valid_d    = valid_q;
            in_ready_c = !valid_q || output_tready;
            in_fire_c  = input_tvalid && in_ready_c;
            if (valid_q && output_tready) valid_d = 1'b0;
            if (in_fire_c) begin
                acc_d = {in_data, acc_q[OUT_DW-1:IN_DW]};
                if (cnt_q == CNT_W'(R - 1)) begin
                    cnt_d   = '0;
                    data_d  = acc_d;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
    end else begin : g_eq
        logic [OUT_DW-1:0] data_q, data_d;
        logic              valid_q, valid_d;

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        always_comb begin
            data_d     = data_q;
            valid_d    = valid_q;
            in_ready_c = !valid_q || output_tready;
            if (valid_q && output_tready) valid_d = 1'b0;
            if (input_tvalid && in_ready_c) begin
                data_d  = in_data;
                valid_d = 1'b1;
            end
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
    end

    assign input_tready  = in_ready_c;
    assign output_tvalid = out_valid;
    assign output_tdata  = OUT_TW'(out_data);

`ifdef THRESH_DWC_TLAST_EN
    localparam int unsigned FC_W = $clog2(FRAME_ELEMS + 1);
    logic [FC_W-1:0] frame_q;
    logic            frame_end_c;

    // frame_q counts elements already sent; the current beat ends the frame when it fills it.
    assign frame_end_c = (frame_q == FC_W'(FRAME_ELEMS - OUT_PE));

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            frame_q <= '0;
        end else if (out_valid && output_tready) begin
            frame_q <= frame_end_c ? '0 : frame_q + FC_W'(OUT_PE);
        end
    end

    assign output_tlast = out_valid && frame_end_c;
`endif

endmodule

// File: tb/tb_thresholding_dwc.sv
// Directed and randomised-handshake checks of thresholding_dwc in down (4->1) and up (1->4) modes.
module tb_thresholding_dwc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        dn_in_ready, dn_in_valid, dn_out_ready, dn_out_valid;
    logic [31:0] dn_in_data;
    logic [7:0]  dn_out_data;
    logic        up_in_ready, up_in_valid, up_out_ready, up_out_valid;
    logic [7:0]  up_in_data;
    logic [31:0] up_out_data;
`ifdef THRESH_DWC_TLAST_EN
    logic        dn_out_tlast, up_out_tlast;
    logic        tl_in_ready, tl_in_valid, tl_out_ready, tl_out_valid, tl_out_tlast;
    logic [31:0] tl_in_data;
    logic [7:0]  tl_out_data;
`endif

    thresholding_dwc #(.ELEM_WIDTH(8), .IN_PE(4), .OUT_PE(1), .FRAME_ELEMS(16)) u_dn (
        .ap_clk(clk), .ap_rst(rst),
        .input_tready(dn_in_ready), .input_tvalid(dn_in_valid), .input_tdata(dn_in_data),
        .output_tready(dn_out_ready), .output_tvalid(dn_out_valid), .output_tdata(dn_out_data)
`ifdef THRESH_DWC_TLAST_EN
        , .output_tlast(dn_out_tlast)
`endif
    );

    thresholding_dwc #(.ELEM_WIDTH(8), .IN_PE(1), .OUT_PE(4), .FRAME_ELEMS(16)) u_up (
        .ap_clk(clk), .ap_rst(rst),
        .input_tready(up_in_ready), .input_tvalid(up_in_valid), .input_tdata(up_in_data),
        .output_tready(up_out_ready), .output_tvalid(up_out_valid), .output_tdata(up_out_data)
`ifdef THRESH_DWC_TLAST_EN
        , .output_tlast(up_out_tlast)
`endif
    );

`ifdef THRESH_DWC_TLAST_EN
    thresholding_dwc #(.ELEM_WIDTH(8), .IN_PE(4), .OUT_PE(1), .FRAME_ELEMS(8)) u_tl (
        .ap_clk(clk), .ap_rst(rst),
        .input_tready(tl_in_ready), .input_tvalid(tl_in_valid), .input_tdata(tl_in_data),
        .output_tready(tl_out_ready), .output_tvalid(tl_out_valid), .output_tdata(tl_out_data),
        .output_tlast(tl_out_tlast)
    );
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] dn_words[$];
    logic [7:0]  dn_exp[$];
    logic [7:0]  dn_got[$];
    int          dn_first_in, dn_first_out, dn_last_out, dn_n_out, dn_rdy_low;
    logic [7:0]  up_elems[$];
    logic [31:0] up_exp[$];
    logic [31:0] up_got[$];
    int          up_last_in, up_first_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Streams dn_words through the 4->1 DUT with random valid/ready percentages.
    task automatic run_dn(input int vpct, input int rpct);
        logic [31:0] w;
        logic [7:0]  prev_d = '0;
        bit          prev_stall = 0;
        bit          fired = 0;
        int          budget = 0;
        dn_got.delete();
        dn_first_in = -1; dn_first_out = -1; dn_last_out = -1; dn_n_out = 0; dn_rdy_low = 0;
        while ((dn_words.size() > 0 || dn_exp.size() > 0) && budget < 40000) begin
            @(negedge clk);
            budget++; cyc++;
            if (prev_stall) begin
                check("dn_hold_valid", 32'(dn_out_valid), 32'd1);
                check("dn_hold_data", 32'(dn_out_data), 32'(prev_d));
            end
            if (fired) dn_in_valid = 1'b0;
            dn_out_ready = ($urandom_range(99) < rpct);
            if (!dn_in_valid && dn_words.size() > 0) dn_in_valid = ($urandom_range(99) < vpct);
            if (dn_words.size() > 0) dn_in_data = dn_words[0];
            #1;
            if (dn_out_valid && !dn_in_ready) dn_rdy_low++;
            if (dn_out_valid && dn_out_ready) begin
                if (dn_first_out < 0) dn_first_out = cyc;
                dn_last_out = cyc;
                dn_n_out++;
                dn_got.push_back(dn_out_data);
                if (dn_exp.size() == 0) check("dn_spurious", 32'(dn_out_valid), 32'd0);
                else check("dn_data", 32'(dn_out_data), 32'(dn_exp.pop_front()));
            end
            fired = dn_in_valid && dn_in_ready;
            if (fired) begin
                if (dn_first_in < 0) dn_first_in = cyc;
                w = dn_words.pop_front();
                for (int l = 0; l < 4; l++) dn_exp.push_back(w[8*l +: 8]);
            end
            prev_stall = dn_out_valid && !dn_out_ready;
            prev_d     = dn_out_data;
        end
        check("dn_drain", 32'(dn_words.size() + dn_exp.size()), 32'd0);
        @(negedge clk);
        dn_in_valid = 1'b0;
        #1;
        check("dn_idle", 32'(dn_out_valid), 32'd0);
    endtask

    // Streams up_elems through the 1->4 DUT with random valid/ready percentages.
    task automatic run_up(input int vpct, input int rpct);
        logic [7:0]  e;
        logic [31:0] acc = '0;
        logic [31:0] prev_d = '0;
        int          nacc = 0;
        bit          prev_stall = 0;
        bit          fired = 0;
        int          budget = 0;
        up_got.delete();
        up_last_in = -1; up_first_out = -1;
        while ((up_elems.size() > 0 || up_exp.size() > 0) && budget < 40000) begin
            @(negedge clk);
            budget++; cyc++;
            if (prev_stall) begin
                check("up_hold_valid", 32'(up_out_valid), 32'd1);
                check("up_hold_data", up_out_data, prev_d);
            end
            if (fired) up_in_valid = 1'b0;
            up_out_ready = ($urandom_range(99) < rpct);
            if (!up_in_valid && up_elems.size() > 0) up_in_valid = ($urandom_range(99) < vpct);
            if (up_elems.size() > 0) up_in_data = up_elems[0];
            #1;
            if (up_out_valid && up_out_ready) begin
                if (up_first_out < 0) up_first_out = cyc;
                up_got.push_back(up_out_data);
                if (up_exp.size() == 0) check("up_spurious", 32'(up_out_valid), 32'd0);
                else check("up_data", up_out_data, up_exp.pop_front());
            end
            fired = up_in_valid && up_in_ready;
            if (fired) begin
                e = up_elems.pop_front();
                acc = {e, acc[31:8]};
                nacc++;
                up_last_in = cyc;
                if (nacc == 4) begin
                    up_exp.push_back(acc);
                    nacc = 0;
                end
            end
            prev_stall = up_out_valid && !up_out_ready;
            prev_d     = up_out_data;
        end
        check("up_drain", 32'(up_elems.size() + up_exp.size()), 32'd0);
        @(negedge clk);
        up_in_valid = 1'b0;
        #1;
        check("up_idle", 32'(up_out_valid), 32'd0);
    endtask

`ifdef THRESH_DWC_TLAST_EN
    task automatic run_tlast();
        int beat = 0, sent = 0, budget = 0;
        tl_out_ready = 1'b1;
        while (beat < 32 && budget < 200) begin
            @(negedge clk);
            budget++;
            tl_in_valid = (sent < 8);
            tl_in_data  = {4{8'(sent)}};
            #1;
            if (tl_out_valid) begin
                beat++;
                check("tlast", 32'(tl_out_tlast), 32'((beat % 8) == 0));
            end
            if (tl_in_valid && tl_in_ready) sent++;
        end
        check("tl_beats", 32'(beat), 32'd32);
        tl_in_valid = 1'b0;
    endtask
`endif

    initial begin
        dn_in_valid = 1'b0; dn_in_data = '0; dn_out_ready = 1'b0;
        up_in_valid = 1'b0; up_in_data = '0; up_out_ready = 1'b0;
`ifdef THRESH_DWC_TLAST_EN
        tl_in_valid = 1'b0; tl_in_data = '0; tl_out_ready = 1'b0;
`endif
        #2 rst = 1'b1;
        #1;
        check("rst_dn_valid", 32'(dn_out_valid), 32'd0);
        check("rst_dn_data", 32'(dn_out_data), 32'd0);
        check("rst_up_valid", 32'(up_out_valid), 32'd0);
        check("rst_up_data", up_out_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_dn_ready", 32'(dn_in_ready), 32'd1);
        check("rst_up_ready", 32'(up_in_ready), 32'd1);

        // Single word split into four bytes on consecutive cycles
        dn_words.push_back(32'h44332211);
        run_dn(100, 100);
        check("d1_b0", 32'(dn_got[0]), 32'h11);
        check("d1_b1", 32'(dn_got[1]), 32'h22);
        check("d1_b2", 32'(dn_got[2]), 32'h33);
        check("d1_b3", 32'(dn_got[3]), 32'h44);
        check("d1_latency", 32'(dn_first_out - dn_first_in), 32'd1);
        check("d1_span", 32'(dn_last_out - dn_first_out), 32'd3);

        // Two back-to-back words: eight beats, no bubble, ready low on 3 of each 4
        dn_words.push_back(32'h88776655);
        dn_words.push_back(32'hCCBBAA99);
        run_dn(100, 100);
        check("d2_beats", 32'(dn_n_out), 32'd8);
        check("d2_span", 32'(dn_last_out - dn_first_out), 32'd7);
        check("d2_rdy_low", 32'(dn_rdy_low), 32'd6);
        check("d2_b4", 32'(dn_got[4]), 32'h99);
        check("d2_b7", 32'(dn_got[7]), 32'hCC);

        // Four bytes packed into one word, one cycle after the fourth input
        up_elems.push_back(8'hA1); up_elems.push_back(8'hB2);
        up_elems.push_back(8'hC3); up_elems.push_back(8'hD4);
        run_up(100, 100);
        check("u1_word", up_got[0], 32'hD4C3B2A1);
        check("u1_count", 32'(up_got.size()), 32'd1);
        check("u1_latency", 32'(up_first_out - up_last_in), 32'd1);

        // Reset with partial words in flight in both converters
        @(negedge clk);
        dn_in_valid = 1'b1; dn_in_data = 32'h44332211; dn_out_ready = 1'b1;
        up_in_valid = 1'b1; up_in_data = 8'hEE; up_out_ready = 1'b1;
        @(negedge clk);
        dn_in_valid = 1'b0; up_in_data = 8'hFF;
        check("r_b0", 32'(dn_out_data), 32'h11);
        @(negedge clk);
        up_in_valid = 1'b0;
        check("r_b1", 32'(dn_out_data), 32'h22);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("r_dn_valid", 32'(dn_out_valid), 32'd0);
        check("r_dn_data", 32'(dn_out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("r_dn_ready", 32'(dn_in_ready), 32'd1);
        dn_words.push_back(32'h0D0C0B0A);
        run_dn(100, 100);
        check("r_dn_first", 32'(dn_got[0]), 32'h0A);
        check("r_dn_beats", 32'(dn_n_out), 32'd4);
        up_elems.push_back(8'h11); up_elems.push_back(8'h12);
        up_elems.push_back(8'h13); up_elems.push_back(8'h14);
        run_up(100, 100);
        check("r_up_word", up_got[0], 32'h14131211);

        // Random handshakes, 1000 words in each direction
        for (int i = 0; i < 1000; i++) dn_words.push_back($urandom);
        run_dn(50, 50);
        for (int i = 0; i < 4000; i++) up_elems.push_back(8'($urandom));
        run_up(50, 50);

`ifdef THRESH_DWC_TLAST_EN
        run_tlast();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
